// File: rtl/cpu_pkg.sv
// Shared definitions for the memory-port arbiter: read-return owner
// encodings, default bus widths and the owner-selection helper.
package cpu_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_D    = 2'd1,
        OWN_I    = 2'd2,
        OWN_G    = 2'd3
    } owner_e;

    // Who will see read data next cycle; stores and idle cycles return nothing.
    function automatic owner_e next_owner(input logic d_gnt, input logic d_we,
                                          input logic i_gnt, input logic g_gnt);
        owner_e own;
        if (d_gnt && !d_we) begin
            own = OWN_D;
        end else if (i_gnt) begin
            own = OWN_I;
        end else if (g_gnt) begin
            own = OWN_G;
        end else begin
            own = OWN_NONE;
        end
        return own;
    endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Debug starvation tracker: counts cycles a pending debug read lost to
// instruction fetch and raises promoted once the limit is reached.
module arb_starve_cnt #(
    parameter int DBG_MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic g_req,
    input  logic i_gnt,
    input  logic g_gnt,
    output logic promoted
);

    logic [3:0] wait_cnt_r;

    // Saturating count of fetch wins over a waiting debug read; cleared once
    // the debug read issues or the request goes away.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= 4'd0;
        end else if (g_gnt || !g_req) begin
            wait_cnt_r <= 4'd0;
        end else if (i_gnt && (wait_cnt_r != 4'd15)) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    assign promoted = (wait_cnt_r >= 4'(DBG_MAX_WAIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for load/store (D), fetch (I) and debug readout (G).
// One access per cycle, read data returned the following cycle.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int DBG_MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    input  logic          g_req,
    input  logic [AW-1:0] g_addr,
    output logic          g_gnt,
    output logic          g_rvalid,
    output logic [DW-1:0] rdata,
    output logic          if_stall,
    output logic          mem_stall,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    logic   d_gnt_s;
    logic   i_gnt_s;
    logic   g_gnt_s;
    logic   promoted_s;
    owner_e owner_r;

    arb_starve_cnt #(
        .DBG_MAX_WAIT(DBG_MAX_WAIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .g_req    (g_req),
        .i_gnt    (i_gnt_s),
        .g_gnt    (g_gnt_s),
        .promoted (promoted_s)
    );

    // Fixed-priority grant: D, then promoted G, then I, then G; nothing in reset.
    always_comb begin
        d_gnt_s = 1'b0;
        i_gnt_s = 1'b0;
        g_gnt_s = 1'b0;
        if (reset) begin
            d_gnt_s = 1'b0;
        end else if (d_req) begin
            d_gnt_s = 1'b1;
        end else if (g_req && promoted_s) begin
            g_gnt_s = 1'b1;
        end else if (i_req) begin
            i_gnt_s = 1'b1;
        end else if (g_req) begin
            g_gnt_s = 1'b1;
        end else begin
            d_gnt_s = 1'b0;
        end
    end

    // RAM command mux from the winning requester; all-zero when idle.
    always_comb begin
        ram_addr  = {AW{1'b0}};
        ram_wdata = {DW{1'b0}};
        case ({d_gnt_s, i_gnt_s, g_gnt_s})
            3'b100: begin
                ram_addr  = d_addr;
                ram_wdata = d_wdata;
            end
            3'b010:  ram_addr = i_addr;
            3'b001:  ram_addr = g_addr;
            default: ram_addr = {AW{1'b0}};
        endcase
    end

    // Remember which requester owns the read data arriving next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_r <= OWN_NONE;
        end else begin
            owner_r <= next_owner(d_gnt_s, d_we, i_gnt_s, g_gnt_s);
        end
    end

    // Decode the return owner; a read in flight across reset is dropped.
    always_comb begin
        d_rvalid = 1'b0;
        i_rvalid = 1'b0;
        g_rvalid = 1'b0;
        if (reset) begin
            d_rvalid = 1'b0;
        end else begin
            case (owner_r)
                OWN_D:   d_rvalid = 1'b1;
                OWN_I:   i_rvalid = 1'b1;
                OWN_G:   g_rvalid = 1'b1;
                default: d_rvalid = 1'b0;
            endcase
        end
    end

    assign d_gnt     = d_gnt_s;
    assign i_gnt     = i_gnt_s;
    assign g_gnt     = g_gnt_s;
    assign ram_en    = d_gnt_s | i_gnt_s | g_gnt_s;
    assign ram_we    = d_gnt_s & d_we;
    assign rdata     = ram_rdata;
    assign if_stall  = i_req & ~i_gnt_s;
    assign mem_stall = d_req & ~d_gnt_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of per-cycle vectors with expected grants,
// a behavioural RAM, a reference memory and a queue of expected read returns.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_req, d_we, i_req, g_req;
    logic [7:0]  d_addr, i_addr, g_addr;
    logic [31:0] d_wdata;
    logic        d_gnt, d_rvalid, i_gnt, i_rvalid, g_gnt, g_rvalid;
    logic [31:0] rdata;
    logic        if_stall, mem_stall, ram_en, ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic        load_mem;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic        dq;
        logic        dwe;
        logic [7:0]  da;
        logic [31:0] dwd;
        logic        iq;
        logic [7:0]  ia;
        logic        gq;
        logic [7:0]  ga;
        logic [2:0]  eg;   // expected {d_gnt, i_gnt, g_gnt}
    } vec_t;

    typedef struct {
        logic [2:0]  own;  // expected {d_rvalid, i_rvalid, g_rvalid}
        logic [31:0] data;
    } ret_t;

    vec_t vecs[$];
    ret_t sb_q[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(8), .DW(32), .DBG_MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .g_req(g_req), .g_addr(g_addr), .g_gnt(g_gnt), .g_rvalid(g_rvalid),
        .rdata(rdata), .if_stall(if_stall), .mem_stall(mem_stall),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    function automatic logic [31:0] init_val(input logic [7:0] a);
        if (a == 8'h20) return 32'h1234_5678;
        return 32'h1000_0000 + ({24'd0, a} * 32'h0001_0101);
    endfunction

    // Behavioural single-port synchronous RAM with registered read output.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int k = 0; k < 256; k++) mem[k] <= init_val(8'(k));
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    function automatic vec_t mk(input logic rst, input logic dq, input logic dwe,
                                input logic [7:0] da, input logic [31:0] dwd,
                                input logic iq, input logic [7:0] ia,
                                input logic gq, input logic [7:0] ga,
                                input logic [2:0] eg);
        vec_t v;
        v.rst = rst; v.dq = dq; v.dwe = dwe; v.da = da; v.dwd = dwd;
        v.iq = iq; v.ia = ia; v.gq = gq; v.ga = ga; v.eg = eg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, check combinational outputs and last cycle's return,
    // then queue what this cycle should return.
    task automatic apply(input vec_t t);
        ret_t       e;
        ret_t       n;
        logic [2:0] exp_rv;
        logic [7:0] exp_addr;
        reset = t.rst; d_req = t.dq; d_we = t.dwe; d_addr = t.da; d_wdata = t.dwd;
        i_req = t.iq; i_addr = t.ia; g_req = t.gq; g_addr = t.ga;
        #3;
        e.own = 3'b000; e.data = 32'd0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        exp_rv = t.rst ? 3'b000 : e.own;
        chk("rvalid", {29'd0, d_rvalid, i_rvalid, g_rvalid}, {29'd0, exp_rv});
        if (exp_rv != 3'b000) chk("rdata", rdata, e.data);
        chk("grants", {29'd0, d_gnt, i_gnt, g_gnt}, {29'd0, t.eg});
        chk("if_stall", {31'd0, if_stall}, {31'd0, t.iq & ~t.eg[1]});
        chk("mem_stall", {31'd0, mem_stall}, {31'd0, t.dq & ~t.eg[2]});
        chk("ram_en", {31'd0, ram_en}, {31'd0, |t.eg});
        chk("ram_we", {31'd0, ram_we}, {31'd0, t.eg[2] & t.dwe});
        exp_addr = t.eg[2] ? t.da : t.eg[1] ? t.ia : t.eg[0] ? t.ga : 8'd0;
        chk("ram_addr", {24'd0, ram_addr}, {24'd0, exp_addr});
        if (t.eg[2] && t.dwe) chk("ram_wdata", ram_wdata, t.dwd);
        n.own = 3'b000; n.data = 32'd0;
        if (t.eg[2] && t.dwe) begin
            ref_mem[t.da] = t.dwd;
        end else if (t.eg != 3'b000) begin
            n.own  = t.eg;
            n.data = ref_mem[exp_addr];
        end
        sb_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 256; k++) ref_mem[k] = init_val(8'(k));
        reset = 1'b1; load_mem = 1'b1;
        d_req = 1'b0; d_we = 1'b0; d_addr = 8'd0; d_wdata = 32'd0;
        i_req = 1'b0; i_addr = 8'd0; g_req = 1'b0; g_addr = 8'd0;
        @(posedge clk);
        #1;
        load_mem = 1'b0;

        // Reset: requests present but nothing granted
        vecs.push_back(mk(1, 1, 1, 8'h01, 32'h5555_AAAA, 1, 8'h00, 1, 8'h20, 3'b000));
        vecs.push_back(mk(1, 0, 0, 8'h00, 32'd0,         1, 8'h00, 0, 8'h00, 3'b000));
        // Fetch stream 0..5
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(0, 0, 0, 8'h00, 32'd0, 1, 8'(k), 0, 8'h00, 3'b010));
        // Store then load 0x10 with fetch stalled
        vecs.push_back(mk(0, 1, 1, 8'h10, 32'hDEAD_BEEF, 1, 8'h06, 0, 8'h00, 3'b100));
        vecs.push_back(mk(0, 1, 0, 8'h10, 32'd0,         1, 8'h06, 0, 8'h00, 3'b100));
        vecs.push_back(mk(0, 0, 0, 8'h00, 32'd0,         1, 8'h06, 0, 8'h00, 3'b010));
        // Triple contention, then starvation: four fetch wins, then G
        vecs.push_back(mk(0, 1, 0, 8'h03, 32'd0, 1, 8'h07, 1, 8'h20, 3'b100));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0, 0, 0, 8'h00, 32'd0, 1, 8'h07, 1, 8'h20, 3'b010));
        vecs.push_back(mk(0, 0, 0, 8'h00, 32'd0, 1, 8'h07, 1, 8'h20, 3'b001));
        vecs.push_back(mk(0, 0, 0, 8'h00, 32'd0, 1, 8'h08, 0, 8'h00, 3'b010));
        // Idle, then debug alone wins
        vecs.push_back(mk(0, 0, 0, 8'h00, 32'd0, 0, 8'h00, 0, 8'h00, 3'b000));
        vecs.push_back(mk(0, 0, 0, 8'h00, 32'd0, 0, 8'h00, 1, 8'h11, 3'b001));
        vecs.push_back(mk(0, 0, 0, 8'h00, 32'd0, 0, 8'h00, 0, 8'h00, 3'b000));

        foreach (vecs[k]) apply(vecs[k]);

        // Reset mid-read: fetch granted, then reset kills its return
        apply(mk(0, 0, 0, 8'h00, 32'd0, 1, 8'h02, 0, 8'h00, 3'b010));
        apply(mk(1, 0, 0, 8'h00, 32'd0, 1, 8'h03, 0, 8'h00, 3'b000));
        apply(mk(0, 0, 0, 8'h00, 32'd0, 1, 8'h03, 0, 8'h00, 3'b010));
        apply(mk(0, 0, 0, 8'h00, 32'd0, 1, 8'h04, 0, 8'h00, 3'b010));

        // Store during reset must not commit; read it back afterwards
        apply(mk(1, 1, 1, 8'h05, 32'hCAFE_F00D, 0, 8'h00, 0, 8'h00, 3'b000));
        apply(mk(0, 1, 0, 8'h05, 32'd0,         0, 8'h00, 0, 8'h00, 3'b100));
        apply(mk(0, 0, 0, 8'h00, 32'd0,         0, 8'h00, 0, 8'h00, 3'b000));

        // Promoted debug still loses to D, then wins over fetch
        for (int k = 0; k < 4; k++)
            apply(mk(0, 0, 0, 8'h00, 32'd0, 1, 8'(9 + k), 1, 8'h20, 3'b010));
        apply(mk(0, 1, 0, 8'h21, 32'd0, 1, 8'h0D, 1, 8'h20, 3'b100));
        apply(mk(0, 0, 0, 8'h00, 32'd0, 1, 8'h0D, 1, 8'h20, 3'b001));
        apply(mk(0, 0, 0, 8'h00, 32'd0, 1, 8'h0D, 0, 8'h00, 3'b010));
        apply(mk(0, 0, 0, 8'h00, 32'd0, 0, 8'h00, 0, 8'h00, 3'b000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
